uart_tx_stim: RTL and testbench

// - 8N1 UART transmitter driving the SoC's serial receive line (ser_rx) from a testbench or formal harness.
// - Bytes are pushed over a valid/ready interface into a small FIFO and serialised LSB-first on ser_tx.
// - Bit timing matches the on-chip UART divider: BIT_CYCLES = 2*clkdiv.
// - Frames are therefore decodable by the existing ser_tx monitor. With BIT_CYCLES=6 that monitor's clkdiv is 3.
//

---
 rtl/uart_tx_stim_if.sv | 10 +
 rtl/uart_tx_stim.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_stim.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_stim_if.sv
// Byte push channel into uart_tx_stim: producer drives in_data/in_valid, transmitter returns in_ready.
// A byte transfers on any clk edge where in_valid && in_ready.
interface uart_tx_stim_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_stim.sv
// 8N1 UART transmitter behind a byte FIFO; defining UART_TX_STIM_PARITY_EN inserts an even parity bit (8E1).
// ser_tx falls 1 cycle after a push into an idle, empty block; in_ready drops only while the FIFO is full.
module uart_tx_stim #(
    parameter int BIT_CYCLES = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    uart_tx_stim_if.slave in_if,
    output logic          ser_tx,
    output logic          busy,
    output logic [7:0]    tx_count
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  CYC_LAST = 8'(BIT_CYCLES - 1);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

`ifdef UART_TX_STIM_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [2:0]  bitn_q, bitn_d;
    logic [7:0]  shift_q, shift_d;
    logic        ser_tx_q, ser_tx_d;
    logic [7:0]  tx_count_q, tx_count_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full_q, full_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        push, pop, empty;
    logic [7:0]  head;
`ifdef UART_TX_STIM_PARITY_EN
    logic        par_q, par_d;
`endif

    // in_ready depends only on the full flop, so a same-cycle pop never admits a push.
    assign empty          = (wr_ptr_q == rd_ptr_q);
    assign push           = in_if.in_valid && !full_q;
    assign in_if.in_ready = !full_q;
    assign head           = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bitn_d     = bitn_q;
        shift_d    = shift_q;
        ser_tx_d   = ser_tx_q;
        tx_count_d = tx_count_q;
        pop        = 1'b0;
`ifdef UART_TX_STIM_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    state_d  = START;
                    ser_tx_d = 1'b0;
                    cyc_d    = 8'd0;
`ifdef UART_TX_STIM_PARITY_EN
                    par_d    = ^head;
`endif
                end
            end
            default: begin
                if (cyc_q != CYC_LAST) begin
                    cyc_d = cyc_q + 8'd1;
                end else begin
                    cyc_d = 8'd0;
                    case (state_q)
                        START: begin
                            state_d  = DATA;
                            bitn_d   = 3'd0;
                            ser_tx_d = shift_q[0];
                        end
                        DATA: begin
                            if (bitn_q == 3'd7) begin
`ifdef UART_TX_STIM_PARITY_EN
                                state_d  = PARITY;
                                ser_tx_d = par_q;
`else
                                state_d  = STOP;
                                ser_tx_d = 1'b1;
`endif
                            end else begin
                                bitn_d   = bitn_q + 3'd1;
                                shift_d  = {1'b0, shift_q[7:1]};
                                ser_tx_d = shift_q[1];
                            end
                        end
`ifdef UART_TX_STIM_PARITY_EN
                        PARITY: begin
                            state_d  = STOP;
                            ser_tx_d = 1'b1;
                        end
`endif
                        STOP: begin
                            // Chaining straight into START keeps queued frames back-to-back.
                            tx_count_d = tx_count_q + 8'd1;
                            if (!empty) begin
                                pop      = 1'b1;
                                shift_d  = head;
                                state_d  = START;
                                ser_tx_d = 1'b0;
`ifdef UART_TX_STIM_PARITY_EN
                                par_d    = ^head;
`endif
                            end else begin
                                state_d  = IDLE;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cyc_q      <= 8'd0;
            bitn_q     <= 3'd0;
            shift_q    <= 8'd0;
            ser_tx_q   <= 1'b1;
            tx_count_q <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
`ifdef UART_TX_STIM_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bitn_q     <= bitn_d;
            shift_q    <= shift_d;
            ser_tx_q   <= ser_tx_d;
            tx_count_q <= tx_count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
`ifdef UART_TX_STIM_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_if.in_data;
    end

    assign ser_tx   = ser_tx_q;
    assign busy     = (state_q != IDLE) || !empty;
    assign tx_count = tx_count_q;
endmodule

// File: tb/tb_uart_tx_stim.sv
// Bench for uart_tx_stim: every cycle ser_tx/busy/tx_count/in_ready are compared with a frame-schedule model.
// Each accepted byte owns a frame starting at max(push_edge+1, previous_start+frame_len).
module tb_uart_tx_stim;
    localparam int BC    = 6;
    localparam int DEPTH = 4;
`ifdef UART_TX_STIM_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int F = NBITS * BC;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ser_tx, busy;
    logic [7:0] tx_count;

    uart_tx_stim_if in_if ();

    uart_tx_stim #(.BIT_CYCLES(BC), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_if    (in_if),
        .ser_tx   (ser_tx),
        .busy     (busy),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         push_e;
        int         start_e;
    } frame_t;

    frame_t     frm[$];
    int         edge_n     = 0;
    int         last_start = -100000;
    logic [7:0] done_cnt   = 8'd0;
    int         n_tests    = 0;
    int         n_fail     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic int fifo_cnt(input int e);
        int n = 0;
        foreach (frm[i]) if (frm[i].start_e > e) n++;
        return n;
    endfunction

    function automatic logic exp_tx(input int e);
        int idx;
        foreach (frm[i]) begin
            if (frm[i].start_e <= e && e < frm[i].start_e + F) begin
                idx = (e - frm[i].start_e) / BC;
                if (idx == 0) return 1'b0;
                if (idx <= 8) return frm[i].b[idx-1];
`ifdef UART_TX_STIM_PARITY_EN
                if (idx == 9) return ^frm[i].b;
`endif
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs 1 ns later.
    task automatic step(input logic v, input logic [7:0] d, input logic rn, output logic acc);
        logic rdy;
        int   s;
        @(negedge clk);
        in_if.in_valid = v;
        in_if.in_data  = d;
        resetn         = rn;
        rdy = (fifo_cnt(edge_n) < DEPTH);
        if (rn) chk("in_ready", in_if.in_ready, rdy);
        acc = v && rn && rdy;
        @(posedge clk);
        edge_n++;
        #1;
        if (!rn) begin
            frm.delete();
            done_cnt   = 8'd0;
            last_start = -100000;
        end else if (acc) begin
            s = (edge_n + 1 > last_start + F) ? edge_n + 1 : last_start + F;
            frm.push_back('{d, edge_n, s});
            last_start = s;
        end
        while (frm.size() > 0 && frm[0].start_e + F <= edge_n) begin
            void'(frm.pop_front());
            done_cnt++;
        end
        chk("ser_tx", ser_tx, exp_tx(edge_n));
        chk("busy", busy, frm.size() != 0);
        chk("tx_count", tx_count, done_cnt);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, a);
    endtask

    task automatic do_reset();
        logic a;
        step(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic drain(input int budget);
        logic a;
        int   n = 0;
        while (frm.size() > 0 && n < budget) begin
            step(1'b0, 8'h00, 1'b1, a);
            n++;
        end
        chk("drain_done", frm.size(), 0);
    endtask

    task automatic run_until(input int target);
        logic a;
        while (edge_n < target) step(1'b0, 8'h00, 1'b1, a);
    endtask

    // Keeps in_valid high with fresh data until n bytes are accepted.
    task automatic push_burst(input int n, input logic use_str, input string str);
        logic       a;
        int         idx = 0;
        int         guard = 0;
        logic [7:0] d;
        while (idx < n && guard < n * F + 100) begin
            d = use_str ? str[idx] : 8'($urandom);
            step(1'b1, d, 1'b1, a);
            if (a) idx++;
            guard++;
        end
        chk("burst_accepted", idx, n);
    endtask

    initial begin
        logic a;
        int   s0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = 8'h00;

        // Reset state
        do_reset();
        do_reset();
        chk("rst_ser_tx", ser_tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", tx_count, 8'd0);
        idle(2);

        // Single 0x48 frame
        step(1'b1, 8'h48, 1'b1, a);
        drain(F + 10);
        idle(3);
        chk("h48_count", tx_count, 8'd1);
        chk("h48_busy", busy, 1'b0);

        // "Hello World" with in_valid held high: back-pressure and full+pop edges
        do_reset();
        push_burst(11, 1'b1, "Hello World");
        drain(12 * F);
        chk("hello_count", tx_count, 8'd11);

        // Reset during DATA bit 3 of 0xA5 with two bytes queued
        do_reset();
        step(1'b1, 8'hA5, 1'b1, a);
        s0 = frm[0].start_e;
        step(1'b1, 8'h11, 1'b1, a);
        step(1'b1, 8'h22, 1'b1, a);
        run_until(s0 + 4 * BC + 2);
        do_reset();
        chk("midrst_ser_tx", ser_tx, 1'b1);
        chk("midrst_count", tx_count, 8'd0);
        chk("midrst_busy", busy, 1'b0);
        idle(F);
        step(1'b1, 8'h3C, 1'b1, a);
        drain(F + 10);
        chk("post_rst_count", tx_count, 8'd1);

        // Random valid/data traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0), 8'($urandom), 1'b1, a);
        end
        drain((DEPTH + 2) * F);

`ifdef UART_TX_STIM_PARITY_EN
        do_reset();
        step(1'b1, 8'h07, 1'b1, a);
        s0 = frm[0].start_e;
        run_until(s0 + 9 * BC + 1);
        chk("par_07", ser_tx, 1'b1);
        drain(F + 10);
        step(1'b1, 8'h03, 1'b1, a);
        s0 = frm[0].start_e;
        run_until(s0 + 9 * BC + 1);
        chk("par_03", ser_tx, 1'b0);
        drain(F + 10);
`endif

        // 256 frames: tx_count wraps back to 0
        do_reset();
        push_burst(256, 1'b0, "");
        drain((DEPTH + 2) * F);
        chk("wrap_count", tx_count, 8'd0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
